// File: rtl/tt_um_serial_subtractor_if.sv
// Pin bundle of the serial subtractor: operand bus, control strobes and status/result outputs.
// The master side drives operands and strobes; the slave side returns the result and status.
interface tt_um_serial_subtractor_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial 8-bit subtractor: operands are loaded over ui_in and A - B is computed
// LSB first through a single borrow flop, one bit per clock.
module tt_um_serial_subtractor (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  tt_um_serial_subtractor_if.slave   bus
);

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic [W-1:0]     r_a_reg,    w_a_reg_nxt;
  logic [W-1:0]     r_b_reg,    w_b_reg_nxt;
  logic [W-1:0]     r_a_sr,     w_a_sr_nxt;
  logic [W-1:0]     r_b_sr,     w_b_sr_nxt;
  logic [W-1:0]     r_d_sr,     w_d_sr_nxt;
  logic             r_brw,      w_brw_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic [W-1:0]     r_res,      w_res_nxt;
  logic             r_done,     w_done_nxt;
  logic             r_borrow_q, w_borrow_q_nxt;
  logic             r_start_q;

  logic w_load_a;
  logic w_load_b;
  logic w_start;
  logic w_start_edge;
  logic w_diff;
  logic w_brw_step;
  logic w_zero;
  logic w_busy;
  logic w_unused;

  assign w_load_a     = bus.uio_in[0];
  assign w_load_b     = bus.uio_in[1];
  assign w_start      = bus.uio_in[2];
  assign w_start_edge = w_start & ~r_start_q;

  // Full-subtractor cell on the current LSBs
  assign w_diff     = r_a_sr[0] ^ r_b_sr[0] ^ r_brw;
  assign w_brw_step = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_brw);

  // ena and the spare control pins carry no function
  assign w_unused = ^{ena, bus.uio_in[7:3]};

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_a_reg_nxt    = r_a_reg;
    w_b_reg_nxt    = r_b_reg;
    w_a_sr_nxt     = r_a_sr;
    w_b_sr_nxt     = r_b_sr;
    w_d_sr_nxt     = r_d_sr;
    w_brw_nxt      = r_brw;
    w_cnt_nxt      = r_cnt;
    w_res_nxt      = r_res;
    w_done_nxt     = r_done;
    w_borrow_q_nxt = r_borrow_q;

    unique case (r_state)
      S_IDLE: begin
        if (w_load_a) w_a_reg_nxt = bus.ui_in;
        if (w_load_b) w_b_reg_nxt = bus.ui_in;
        // Working copies take the pre-edge operands; a same-cycle load is for the next run
        if (w_start_edge) begin
          w_a_sr_nxt  = r_a_reg;
          w_b_sr_nxt  = r_b_reg;
          w_brw_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_d_sr_nxt = {w_diff, r_d_sr[W-1:1]};
        w_a_sr_nxt = {1'b0, r_a_sr[W-1:1]};
        w_b_sr_nxt = {1'b0, r_b_sr[W-1:1]};
        w_brw_nxt  = w_brw_step;
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_res_nxt      = {w_diff, r_d_sr[W-1:1]};
          w_borrow_q_nxt = w_brw_step;
          w_done_nxt     = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a_reg    <= '0;
      r_b_reg    <= '0;
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_d_sr     <= '0;
      r_brw      <= 1'b0;
      r_cnt      <= '0;
      r_res      <= '0;
      r_done     <= 1'b0;
      r_borrow_q <= 1'b0;
      r_start_q  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a_reg    <= w_a_reg_nxt;
      r_b_reg    <= w_b_reg_nxt;
      r_a_sr     <= w_a_sr_nxt;
      r_b_sr     <= w_b_sr_nxt;
      r_d_sr     <= w_d_sr_nxt;
      r_brw      <= w_brw_nxt;
      r_cnt      <= w_cnt_nxt;
      r_res      <= w_res_nxt;
      r_done     <= w_done_nxt;
      r_borrow_q <= w_borrow_q_nxt;
      r_start_q  <= w_start;
    end
  end

  assign w_busy = (r_state == S_SHIFT);
  assign w_zero = (r_res == '0);

  assign bus.uo_out  = r_res;
  assign bus.uio_out = {w_zero, r_borrow_q, r_done, w_busy, 4'b0000};
  assign bus.uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Self-checking bench for the serial subtractor: directed cases plus random operands
// compared against an arithmetic reference of A - B.
module tb_tt_um_serial_subtractor;

  logic clk;
  logic rst_n;
  logic ena;

  tt_um_serial_subtractor_if bus ();

  tt_um_serial_subtractor u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference operand registers as seen by software
  int a_m;
  int b_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_ab(input int a, input int b);
    bus.ui_in  = 8'(a);
    bus.uio_in = 8'h01;
    tick();
    bus.ui_in  = 8'(b);
    bus.uio_in = 8'h02;
    tick();
    bus.uio_in = 8'h00;
    a_m = a;
    b_m = b;
  endtask

  // Pulse start, measure busy length and check the outcome against the model
  task automatic run_op(input string tag);
    int exp_d;
    int busy_n;
    logic [7:0] pre;
    exp_d  = (a_m - b_m + 256) % 256;
    pre    = bus.uo_out;
    bus.uio_in = 8'h04;
    tick();
    bus.uio_in = 8'h00;
    busy_n = 0;
    while (bus.uio_out[4] === 1'b1 && busy_n < 20) begin
      check({tag, "_stable"}, 32'(bus.uo_out), 32'(pre));
      busy_n++;
      tick();
    end
    check({tag, "_busylen"}, 32'(busy_n), 32'd8);
    check({tag, "_res"}, 32'(bus.uo_out), 32'(exp_d));
    check({tag, "_borrow"}, 32'(bus.uio_out[6]), 32'(a_m < b_m));
    check({tag, "_zero"}, 32'(bus.uio_out[7]), 32'(exp_d == 0));
    check({tag, "_done"}, 32'(bus.uio_out[5]), 32'd1);
    check({tag, "_low"}, 32'(bus.uio_out[3:0]), 32'd0);
  endtask

  initial begin
    int busy_seen;
    n_vec      = 0;
    n_err      = 0;
    a_m        = 0;
    b_m        = 0;
    ena        = 1'b1;
    rst_n      = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    tick();
    tick();
    check("rst_uo", 32'(bus.uo_out), 32'h00);
    check("rst_uio", 32'(bus.uio_out), 32'h80);
    check("rst_oe", 32'(bus.uio_oe), 32'hF0);
    rst_n = 1'b1;
    tick();

    load_ab(100, 37);
    run_op("a100b37");
    load_ab(37, 100);
    run_op("a37b100");
    load_ab(0, 1);
    run_op("a0b1");

    // Both strobes in one cycle take the same byte
    bus.ui_in  = 8'd55;
    bus.uio_in = 8'h03;
    tick();
    bus.uio_in = 8'h00;
    a_m = 55;
    b_m = 55;
    run_op("same55");

    for (int i = 0; i < 24; i++) begin
      load_ab(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      run_op("rand");
    end

    // Controls ignored while busy; held start must not retrigger
    load_ab(200, 50);
    bus.uio_in = 8'h04;
    tick();
    bus.uio_in = 8'h00;
    tick();
    bus.ui_in  = 8'd9;
    bus.uio_in = 8'h05;
    tick();
    bus.uio_in = 8'h04;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      busy_seen += int'(bus.uio_out[4]);
      tick();
    end
    check("ign_busylen", 32'(busy_seen), 32'd6);
    check("ign_res", 32'(bus.uo_out), 32'd150);
    check("ign_done", 32'(bus.uio_out[5]), 32'd1);
    bus.uio_in = 8'h00;
    tick();
    run_op("ign_rerun");

    // Reset mid-operation discards everything, including operands
    load_ab(10, 3);
    bus.uio_in = 8'h04;
    tick();
    bus.uio_in = 8'h00;
    repeat (3) tick();
    check("mid_busy", 32'(bus.uio_out[4]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_uo", 32'(bus.uo_out), 32'h00);
    check("mid_rst_uio", 32'(bus.uio_out), 32'h80);
    tick();
    tick();
    rst_n = 1'b1;
    a_m = 0;
    b_m = 0;
    run_op("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
